wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline writeback (MEM/WB register outputs) and a multi-cycle multiply/divide unit that completes out of band. Pipeline writebacks always win; muldiv results queue in a 2-entry FIFO and drain on any cycle the pipeline does not write. A starvation counter requests a one-cycle bubble into MEM/WB so queued results cannot wait indefinitely. A pending-register mask feeds the hazard unit so readers and WAW writers of queued destinations stall.

---
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, muldiv
// results wait in a 2-entry FIFO with a starvation-driven bubble request.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_regwrite,
  input  logic        wb_memtoreg,
  input  logic [31:0] wb_readdata,
  input  logic [31:0] wb_aluresult,
  input  logic [4:0]  wb_rd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        bubble_req,
  output logic [31:0] md_pending
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a muldiv result transfers at a rising edge where md_valid and
  // md_ready are both 1; md_ready never depends on md_valid or a same-cycle pop.
  logic [4:0]  e_rd   [2];
  logic [31:0] e_data [2];
  logic [1:0]  count;
  logic [3:0]  starve_cnt;

  logic       pipe_busy;
  logic       head_valid;
  logic       pop;
  logic       push;
  logic       wr_idx;

  assign pipe_busy  = wb_regwrite && (wb_rd != 5'd0);
  assign head_valid = (count != 2'd0);
  assign pop        = !rst && !pipe_busy && head_valid;
  assign md_ready   = !rst && (count < 2'd2);
  // rd=0 results are acknowledged but never stored.
  assign push       = md_valid && md_ready && (md_rd != 5'd0);
  assign wr_idx     = (count == 2'd2) || ((count == 2'd1) && !pop);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!rst) begin
      if (pipe_busy) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_memtoreg ? wb_readdata : wb_aluresult;
      end else if (head_valid) begin
        rf_we    = 1'b1;
        rf_waddr = e_rd[0];
        rf_wdata = e_data[0];
      end
    end
  end

  always_comb begin
    md_pending = 32'd0;
    if (count != 2'd0) md_pending[e_rd[0]] = 1'b1;
    if (count == 2'd2) md_pending[e_rd[1]] = 1'b1;
    if (rst) md_pending = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      starve_cnt <= 4'd0;
      bubble_req <= 1'b0;
      e_rd[0]    <= 5'd0;
      e_rd[1]    <= 5'd0;
      e_data[0]  <= 32'd0;
      e_data[1]  <= 32'd0;
    end else begin
      if (pop) begin
        e_rd[0]   <= e_rd[1];
        e_data[0] <= e_data[1];
      end
      // A push into slot 0 while popping overrides the shift above.
      if (push) begin
        e_rd[wr_idx]   <= md_rd;
        e_data[wr_idx] <= md_data;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (!head_valid || pop)
        starve_cnt <= 4'd0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      bubble_req <= head_valid && !pop &&
                    ((starve_cnt == LIMIT - 4'd1) ||
                     ((starve_cnt == LIMIT) && !bubble_req));
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter with hand-computed expectations
// checked by immediate assertions.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [31:0] wb_readdata;
  logic [31:0] wb_aluresult;
  logic [4:0]  wb_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        bubble_req;
  logic [31:0] md_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult), .wb_rd(wb_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .bubble_req(bubble_req), .md_pending(md_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".wdata"}, rf_wdata, d);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_regwrite = 1'b0; wb_memtoreg = 1'b0; wb_readdata = '0;
    wb_aluresult = '0; wb_rd = '0; md_valid = 1'b0; md_rd = '0; md_data = '0;
    tick(); tick();
    chk_port("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.ready", 32'(md_ready), 32'd0);
    chk("rst.pending", md_pending, 32'd0);
    chk("rst.bubble", 32'(bubble_req), 32'd0);
    rst = 1'b0;
    settle();
    chk("post_rst.ready", 32'(md_ready), 32'd1);

    // Idle pipeline: push rd=5, written the next cycle.
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'hDEADBEEF;
    settle();
    chk_port("idle.push", 1'b0, 5'd0, 32'd0);
    tick();
    md_valid = 1'b0;
    settle();
    chk_port("idle.drain", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("idle.pending", md_pending, 32'h0000_0020);
    tick();
    chk("idle.pending_clr", md_pending, 32'd0);
    chk_port("idle.after", 1'b0, 5'd0, 32'd0);

    // Priority: pipeline write wins over queued rd=7.
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_memtoreg = 1'b1;
    wb_readdata = 32'h11; wb_aluresult = 32'h22;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
    settle();
    chk_port("prio.push", 1'b1, 5'd3, 32'h11);
    tick();
    md_valid = 1'b0;
    settle();
    chk_port("prio.load", 1'b1, 5'd3, 32'h11);
    chk("prio.pending", md_pending, 32'h0000_0080);
    wb_memtoreg = 1'b0;
    settle();
    chk_port("prio.alu", 1'b1, 5'd3, 32'h22);
    tick();
    wb_regwrite = 1'b0;
    settle();
    chk_port("prio.drain", 1'b1, 5'd7, 32'h77);
    tick();
    chk_port("prio.empty", 1'b0, 5'd0, 32'd0);

    // Full FIFO: rd=1, rd=2 queued; rd=4 held until a pop frees a slot.
    wb_regwrite = 1'b1; wb_rd = 5'd3;
    md_valid = 1'b1; md_rd = 5'd1; md_data = 32'h101;
    tick();
    md_rd = 5'd2; md_data = 32'h202;
    settle();
    chk("full.ready1", 32'(md_ready), 32'd1);
    tick();
    md_rd = 5'd4; md_data = 32'h404;
    settle();
    chk("full.ready0", 32'(md_ready), 32'd0);
    chk("full.pending", md_pending, 32'h0000_0006);
    wb_regwrite = 1'b0;
    settle();
    chk_port("full.drain1", 1'b1, 5'd1, 32'h101);
    chk("full.no_pass", 32'(md_ready), 32'd0);
    tick();
    chk("full.ready_again", 32'(md_ready), 32'd1);
    chk_port("full.drain2", 1'b1, 5'd2, 32'h202);
    tick();
    md_valid = 1'b0;
    settle();
    chk_port("full.drain3", 1'b1, 5'd4, 32'h404);
    chk("full.pending3", md_pending, 32'h0000_0010);
    tick();
    chk_port("full.empty", 1'b0, 5'd0, 32'd0);

    // Starvation: continuous pipeline writes, bubble on the 5th waiting cycle.
    wb_regwrite = 1'b1; wb_rd = 5'd3;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h909;
    tick();
    md_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("starve.bubble%0d", i), 32'(bubble_req), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve.waddr%0d", i), 32'(rf_waddr), 32'd3);
      if (i < 4) tick();
    end
    tick();
    wb_regwrite = 1'b0;
    settle();
    chk("starve.bubble_off", 32'(bubble_req), 32'd0);
    chk_port("starve.drain", 1'b1, 5'd9, 32'h909);
    tick();
    chk("starve.pending", md_pending, 32'd0);
    chk("starve.bubble_idle", 32'(bubble_req), 32'd0);

    // $0 handling.
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
    settle();
    chk("zero.ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 1'b0;
    settle();
    chk("zero.pending", md_pending, 32'd0);
    chk_port("zero.nowrite", 1'b0, 5'd0, 32'd0);
    wb_regwrite = 1'b1; wb_rd = 5'd3;
    md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h606;
    tick();
    md_valid = 1'b0; wb_rd = 5'd0;
    settle();
    chk_port("zero.drain", 1'b1, 5'd6, 32'h606);
    tick();
    chk_port("zero.suppressed", 1'b0, 5'd0, 32'd0);

    // Reset mid-queue discards both entries.
    wb_rd = 5'd3;
    md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hA0A;
    tick();
    md_rd = 5'd11; md_data = 32'hB0B;
    tick();
    md_valid = 1'b0;
    settle();
    chk("rq.pending", md_pending, 32'h0000_0C00);
    chk("rq.ready", 32'(md_ready), 32'd0);
    rst = 1'b1;
    settle();
    chk_port("rq.in_rst", 1'b0, 5'd0, 32'd0);
    chk("rq.in_rst_pending", md_pending, 32'd0);
    tick();
    rst = 1'b0; wb_regwrite = 1'b0;
    settle();
    chk("rq.pending_after", md_pending, 32'd0);
    chk_port("rq.after", 1'b0, 5'd0, 32'd0);
    chk("rq.ready_after", 32'(md_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
